// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one single-port memory bus with timeout.
// Optional round-robin on IDLE conflicts when MEM_ARB_RR_EN is defined; default is fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [DATA_W-1:0] iRdata,
  output logic              iAck,
  input  logic              dReq,
  input  logic              dWr,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic [DATA_W-1:0] dRdata,
  output logic              dAck,
  output logic              err,
  output logic              stall,
  output logic              mCe,
  output logic              mWr,
  output logic [ADDR_W-1:0] mAddr,
  output logic [DATA_W-1:0] mWdata,
  input  logic [DATA_W-1:0] mRdata,
  input  logic              mRdy
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          i_elig;
  logic          d_elig;
  logic          grant_d;

  // A requester whose ack is high this cycle already got its answer; do not re-grant it.
  assign i_elig = iReq & ~iAck;
  assign d_elig = dReq & ~dAck;
  assign stall  = i_elig | d_elig;

`ifdef MEM_ARB_RR_EN
  logic last_gnt_d;
  assign grant_d = d_elig & (~i_elig | ~last_gnt_d);
`else
  assign grant_d = d_elig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mCe    <= 1'b0;
      mWr    <= 1'b0;
      mAddr  <= '0;
      mWdata <= '0;
      iRdata <= '0;
      dRdata <= '0;
      iAck   <= 1'b0;
      dAck   <= 1'b0;
      err    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt_d <= 1'b0;
`endif
    end else begin
      iAck <= 1'b0;
      dAck <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= DBUS;
            mCe    <= 1'b1;
            mWr    <= dWr;
            mAddr  <= dAddr;
            mWdata <= dWdata;
            cnt    <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_d <= 1'b1;
`endif
          end else if (i_elig) begin
            state <= IBUS;
            mCe   <= 1'b1;
            mWr   <= 1'b0;
            mAddr <= iAddr;
            cnt   <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_d <= 1'b0;
`endif
          end
        end
        IBUS: begin
          if (mRdy) begin
            iRdata <= mRdata;
            iAck   <= 1'b1;
            mCe    <= 1'b0;
            mWr    <= 1'b0;
            state  <= IDLE;
          end else if (cnt == CNT_MAX) begin
            iRdata <= '0;
            iAck   <= 1'b1;
            err    <= 1'b1;
            mCe    <= 1'b0;
            mWr    <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DBUS: begin
          // mWr still holds the latched dWr, so it tells load from store here.
          if (mRdy) begin
            if (!mWr) dRdata <= mRdata;
            dAck  <= 1'b1;
            mCe   <= 1'b0;
            mWr   <= 1'b0;
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            if (!mWr) dRdata <= '0;
            dAck  <= 1'b1;
            err   <= 1'b1;
            mCe   <= 1'b0;
            mWr   <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        iReq;
  logic [31:0] iAddr;
  logic [31:0] iRdata;
  logic        iAck;
  logic        dReq;
  logic        dWr;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [31:0] dRdata;
  logic        dAck;
  logic        err;
  logic        stall;
  logic        mCe;
  logic        mWr;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [31:0] mRdata;
  logic        mRdy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iAck(iAck),
    .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dAck(dAck),
    .err(err), .stall(stall),
    .mCe(mCe), .mWr(mWr), .mAddr(mAddr), .mWdata(mWdata), .mRdata(mRdata), .mRdy(mRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_bus;
  } vec_t;

  int          rdy_delay = 0;
  logic [31:0] rdata_val = 32'h0;
  int          bus_cyc   = 0;
  int          mce_total = 0;
  acc_t        log_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  assign mRdata = rdata_val;

  // Memory model: answers rdy_delay cycles into each mCe burst, logs each burst's first cycle.
  always @(negedge clk) begin
    acc_t a;
    if (mCe) begin
      if (bus_cyc == 0) begin
        a.wr = mWr; a.addr = mAddr; a.wdata = mWdata;
        log_q.push_back(a);
      end
      mRdy = (bus_cyc == rdy_delay);
      bus_cyc++;
      mce_total++;
    end else begin
      mRdy = 1'b0;
      bus_cyc = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input logic is_d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rd, output logic e);
    logic done;
    @(negedge clk);
    if (is_d) begin
      dReq = 1'b1; dWr = wr; dAddr = addr; dWdata = wdata;
    end else begin
      iReq = 1'b1; iAddr = addr;
    end
    lat = 0; rd = '0; e = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      lat++;
      if (is_d ? dAck : iAck) begin
        rd = is_d ? dRdata : iRdata;
        e = err;
        done = 1'b1;
      end
    end
    iReq = 1'b0;
    dReq = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          n0;
    int          m0;
    int          winner;
    int          expw;
    logic        done;

    tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        0,   32'h24020005, 32'h24020005, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b0, 32'h300, 32'h0,        3,   32'h11223344, 32'h11223344, 1'b0, 4};
    tbl[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1,   32'hAAAA5555, 32'h11223344, 1'b0, 2};
    tbl[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        14,  32'h0BADCAFE, 32'h0BADCAFE, 1'b0, 15};
    tbl[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        255, 32'h99999999, 32'h0,        1'b1, 15};
    tbl[5] = '{1'b0, 1'b0, 32'h108, 32'h0,        255, 32'h77777777, 32'h0,        1'b1, 15};
    tbl[6] = '{1'b1, 1'b1, 32'h400, 32'h12345678, 255, 32'h66666666, 32'h0,        1'b1, 15};
    tbl[7] = '{1'b1, 1'b0, 32'h404, 32'h0,        0,   32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1};

    rst = 1'b1; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWr = 1'b0; dAddr = '0; dWdata = '0;
    #2;
    check("rst_mCe", {31'b0, mCe}, 32'h0);
    check("rst_mWr", {31'b0, mWr}, 32'h0);
    check("rst_mAddr", mAddr, 32'h0);
    check("rst_mWdata", mWdata, 32'h0);
    check("rst_rdata", iRdata | dRdata, 32'h0);
    check("rst_pulses", {29'b0, iAck, dAck, err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, cycle by cycle
    rdy_delay = 0; rdata_val = 32'h24020005;
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h100;
    #1 check("c0_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    check("c1_mCe", {31'b0, mCe}, 32'h1);
    check("c1_mAddr", mAddr, 32'h100);
    check("c1_mWr", {31'b0, mWr}, 32'h0);
    check("c1_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    check("c2_iAck", {31'b0, iAck}, 32'h1);
    check("c2_iRdata", iRdata, 32'h24020005);
    check("c2_stall", {31'b0, stall}, 32'h0);
    iReq = 1'b0;

    for (int t = 0; t < 8; t++) begin
      rdy_delay = tbl[t].delay;
      rdata_val = tbl[t].rdata;
      n0 = log_q.size();
      m0 = mce_total;
      run_txn(tbl[t].is_d, tbl[t].wr, tbl[t].addr, tbl[t].wdata, lat, rd, e);
      check($sformatf("v%0d_latency", t), lat, tbl[t].exp_bus + 1);
      check($sformatf("v%0d_rdata", t), rd, tbl[t].exp_rd);
      check($sformatf("v%0d_err", t), {31'b0, e}, {31'b0, tbl[t].exp_err});
      check($sformatf("v%0d_mce_cycles", t), mce_total - m0, tbl[t].exp_bus);
      check($sformatf("v%0d_bursts", t), log_q.size() - n0, 1);
      if (log_q.size() > n0) begin
        check($sformatf("v%0d_mAddr", t), log_q[n0].addr, tbl[t].addr);
        check($sformatf("v%0d_mWr", t), {31'b0, log_q[n0].wr}, {31'b0, tbl[t].is_d & tbl[t].wr});
        if (tbl[t].is_d && tbl[t].wr)
          check($sformatf("v%0d_mWdata", t), log_q[n0].wdata, tbl[t].wdata);
      end
    end

    // Same-edge conflict: data store first, one idle cycle, then fetch
    do_reset();
    rdy_delay = 0; rdata_val = 32'h55AA55AA;
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h104;
    dReq = 1'b1; dWr = 1'b1; dAddr = 32'h200; dWdata = 32'hDEADBEEF;
    @(negedge clk);
    check("cf_d_mCe", {31'b0, mCe}, 32'h1);
    check("cf_d_mWr", {31'b0, mWr}, 32'h1);
    check("cf_d_mAddr", mAddr, 32'h200);
    check("cf_d_mWdata", mWdata, 32'hDEADBEEF);
    @(negedge clk);
    check("cf_dAck", {30'b0, dAck, iAck}, 32'h2);
    check("cf_idle_mCe", {31'b0, mCe}, 32'h0);
    dReq = 1'b0;
    @(negedge clk);
    check("cf_i_mCe", {31'b0, mCe}, 32'h1);
    check("cf_i_mAddr", mAddr, 32'h104);
    check("cf_i_mWr", {31'b0, mWr}, 32'h0);
    @(negedge clk);
    check("cf_iAck", {30'b0, dAck, iAck}, 32'h1);
    check("cf_iRdata", iRdata, 32'h55AA55AA);
    check("cf_dRdata_kept", dRdata, 32'h0);
    iReq = 1'b0;

    // Reset in the second DBUS cycle, then a fresh transaction for the held request
    rdy_delay = 255; rdata_val = 32'h76543210;
    @(negedge clk);
    dReq = 1'b1; dWr = 1'b0; dAddr = 32'h500;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rm_mCe", {31'b0, mCe}, 32'h0);
    check("rm_pulses", {29'b0, iAck, dAck, err}, 32'h0);
    check("rm_iRdata", iRdata, 32'h0);
    check("rm_mAddr", mAddr, 32'h0);
    @(negedge clk);
    rst = 1'b0; rdy_delay = 0;
    n0 = log_q.size();
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (dAck) done = 1'b1;
    end
    check("rm_reack", {31'b0, done}, 32'h1);
    check("rm_dRdata", dRdata, 32'h76543210);
    check("rm_bursts", log_q.size() - n0, 1);
    if (log_q.size() > n0) check("rm_mAddr2", log_q[n0].addr, 32'h500);
    dReq = 1'b0;

    // Fetch request still high at the edge ending the ack cycle
    rdy_delay = 2; rdata_val = 32'h13572468;
    n0 = log_q.size();
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h180;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (iAck) done = 1'b1;
    end
    check("hold_ack", {31'b0, done}, 32'h1);
    @(posedge clk);
    #1 iReq = 1'b0;
    @(negedge clk);
    check("hold_no_regrant", {30'b0, mCe, iAck}, 32'h0);
    repeat (3) @(negedge clk);
    check("hold_bursts", log_q.size() - n0, 1);

    // Four fresh conflicts in a row
    do_reset();
    rdy_delay = 0; rdata_val = 32'h0;
    n0 = log_q.size();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      iReq = 1'b1; iAddr = 32'h1000 + r;
      dReq = 1'b1; dWr = 1'b0; dAddr = 32'h2000 + r;
      winner = -1;
      for (int k = 0; k < 20 && winner < 0; k++) begin
        @(negedge clk);
        if (iAck && dAck) winner = 2;
        else if (dAck) winner = 1;
        else if (iAck) winner = 0;
      end
`ifdef MEM_ARB_RR_EN
      expw = (r % 2 == 0) ? 1 : 0;
`else
      expw = 1;
`endif
      check($sformatf("order_%0d", r), winner, expw);
      iReq = 1'b0;
      dReq = 1'b0;
    end
    @(negedge clk);
    check("order_bursts", log_q.size() - n0, 4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch requester (IF) and the data requester (MEM stage: loads, stores, ll/sc).
- Sits between the core and the external memory. Grants one requester at a time and tracks the transaction with a small FSM.
- Returns read data and a one-cycle acknowledge to the granted requester. Drives a stall to the pipeline while any request is outstanding.
- Bounds every transaction with a timeout counter that reports a bus error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum bus-state cycles without mRdy before the transaction is forced to finish with an error; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- iReq  in  1  instruction fetch request; held until iAck.
- iAddr  in  ADDR_W  fetch address; stable while iReq=1.
- iRdata  out  DATA_W  fetched word; valid in the iAck cycle.
- iAck  out  1  one-cycle completion pulse to IF.
- dReq  in  1  data request; held until dAck.
- dWr  in  1  1=store, 0=load; stable while dReq=1.
- dAddr  in  ADDR_W  data address.
- dWdata  in  DATA_W  store data.
- dRdata  out  DATA_W  load data; valid in the dAck cycle.
- dAck  out  1  one-cycle completion pulse to MEM.
- err  out  1  bus-error pulse, coincident with the iAck/dAck of a timed-out transaction.
- stall  out  1  combinational: (iReq & ~iAck) | (dReq & ~dAck).
- mCe  out  1  memory chip enable.
- mWr  out  1  memory write enable.
- mAddr  out  ADDR_W  memory address.
- mWdata  out  DATA_W  memory write data.
- mRdata  in  DATA_W  memory read data; sampled when mRdy=1.
- mRdy  in  1  memory completes the current access.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, mCe=0, mWr=0, mAddr=0, mWdata=0, iRdata=0, dRdata=0, iAck=0, dAck=0, err=0, cnt=0, lastGnt=INST.
- FSM states: IDLE, IBUS, DBUS. All memory-side outputs are registered.
- IDLE, per requester: eligible = req & ~ack. A requester whose ack is high this cycle is not re-granted, so there are no duplicate transactions.
- IDLE grant: dReq eligible -> DBUS; else iReq eligible -> IBUS; else stay. The default policy is fixed data priority.
- On the grant edge:
  - Latch mAddr from the granted address and set mCe=1.
  - For a data grant, set mWr=dWr and mWdata=dWdata. For an instruction grant, set mWr=0.
  - Set cnt=0 and record lastGnt.
- IBUS/DBUS, at each edge:
  - If mRdy=1: capture mRdata into iRdata (IBUS) or dRdata (DBUS, load only; a store leaves dRdata unchanged). Pulse the matching ack for the next cycle, clear mCe/mWr, and go to IDLE.
  - Else if cnt==TIMEOUT-1: pulse ack and err, load the matching rdata with 0 (store: unchanged), clear mCe/mWr, and go to IDLE.
  - Else cnt=cnt+1.
- Latency: request seen at edge 0 -> mCe high in cycle 1 -> mRdy in cycle 1 -> ack in cycle 2. The minimum is 2 cycles per access.
- Back-to-back: the ack cycle is spent in IDLE, so the other pending requester is granted at the edge ending the ack cycle. One idle bus cycle separates transactions.
- Ack and err are single-cycle pulses, never asserted together for both requesters.
- mRdy outside IBUS/DBUS is ignored.
- Request inputs dropped mid-transaction do not abort it; the ack is still issued.
- Reset asserted mid-transaction drops mCe immediately and no ack is issued. After release, a still-held request is served from scratch.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on a conflict in IDLE, round-robin applies; the requester not in lastGnt wins. Reset lastGnt=INST, so data wins the first conflict.
- Undefined: fixed data priority. Instruction fetch can starve under continuous dReq; this is acceptable because the pipeline stalls fetch during MEM accesses.

Test Plan:
- iReq=1, iAddr=0x100, mRdy=1 in the first bus cycle, mRdata=0x24020005 -> cycle 1: mCe=1, mAddr=0x100, mWr=0; cycle 2: iAck=1, iRdata=0x24020005; stall=1 in cycles 0-1, 0 in cycle 2.
- Same edge: iReq (0x104) and dReq store (0x200, 0xDEADBEEF) -> DBUS first with mWr=1 and mWdata=0xDEADBEEF; dAck; one IDLE cycle; IBUS with mAddr=0x104; iAck. dRdata unchanged.
- dReq load 0x300, mRdy held 0, TIMEOUT=15 -> mCe high for exactly 15 cycles, then dAck=1, err=1, dRdata=0, state IDLE.
- rst pulsed in the second DBUS cycle -> mCe=0 asynchronously, no dAck, outputs at reset values. After release with dReq still held -> a fresh DBUS, completed normally.
- iReq held through iAck -> no second IBUS started in the ack cycle; exactly one mCe burst per request.
- Both requests continuously re-raised for 4 transactions -> MEM_ARB_RR_EN defined: D,I,D,I; undefined: D,D,D,D.
